// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline-stage registers.
//   pipe_state_t      : occupancy state of a stage register (EMPTY/ONE/TWO)
//   *_t structs       : per-stage packed payloads so stage logic packs and
//                       unpacks by field name
//   *_W localparams   : payload widths derived from the structs
//   state_occupancy() : maps a state to its held-entry count
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    function automatic logic [1:0] state_occupancy(input pipe_state_t s);
        logic [1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at its maximum value.
//   clk   : clock
//   clr   : synchronous clear, wins over inc
//   inc   : count one event this cycle
//   count : current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline-stage register with valid/ready handshake,
// flush-to-bubble and an optional two-entry skid buffer.
//   clk, rst_b          : clock; synchronous active-high reset
//   flush               : drop all held entries (loads BUBBLE)
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data head payload
//   occupancy           : held entries (0..2), mirrors the FSM state
//   stall_cnt           : saturating count of out_valid & ~out_ready cycles
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high. A producer holding valid keeps its data stable until the
// transfer; valid never drops without a transfer (or a flush here).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               SKID   = 1,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t      state_q, state_d, fsm_state_d;
    logic [WIDTH-1:0] main_q, main_d, fsm_main_d;
    logic [WIDTH-1:0] skid_q, skid_d, fsm_skid_d;
    logic             accept, pop;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_occupancy(state_q);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic in_ready_q;

            // Ready is registered so no combinational path runs from
            // out_ready back to in_ready; the skid entry absorbs the one
            // beat that may arrive while downstream is stalled.
            always_ff @(posedge clk) begin
                if (rst_b) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != TWO);
                end
            end

            assign in_ready = in_ready_q;

            always_comb begin
                fsm_state_d = state_q;
                fsm_main_d  = main_q;
                fsm_skid_d  = skid_q;
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            fsm_state_d = ONE;
                            fsm_main_d  = in_data;
                        end
                    end
                    ONE: begin
                        if (accept && pop) begin
                            fsm_main_d = in_data;
                        end else if (accept) begin
                            fsm_state_d = TWO;
                            fsm_skid_d  = in_data;
                        end else if (pop) begin
                            fsm_state_d = EMPTY;
                            fsm_main_d  = BUBBLE;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            fsm_state_d = ONE;
                            fsm_main_d  = skid_q;
                            fsm_skid_d  = BUBBLE;
                        end
                    end
                    default: begin
                        fsm_state_d = EMPTY;
                        fsm_main_d  = BUBBLE;
                        fsm_skid_d  = BUBBLE;
                    end
                endcase
            end
        end else begin : g_noskid
            // Single entry: it can only be replaced in the same cycle it
            // leaves, so readiness depends on out_ready combinationally.
            assign in_ready = ~out_valid | out_ready;

            always_comb begin
                fsm_state_d = state_q;
                fsm_main_d  = main_q;
                fsm_skid_d  = skid_q;
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            fsm_state_d = ONE;
                            fsm_main_d  = in_data;
                        end
                    end
                    ONE: begin
                        if (accept) begin
                            fsm_main_d = in_data;
                        end else if (pop) begin
                            fsm_state_d = EMPTY;
                            fsm_main_d  = BUBBLE;
                        end
                    end
                    default: begin
                        fsm_state_d = EMPTY;
                        fsm_main_d  = BUBBLE;
                    end
                endcase
            end
        end
    endgenerate

    // Flush overrides whatever the handshake would have done this cycle;
    // an entry offered alongside it is dropped.
    always_comb begin
        state_d = fsm_state_d;
        main_d  = fsm_main_d;
        skid_d  = fsm_skid_d;
        if (flush) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Only reset clears the stall count; flush leaves it alone.
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .clr  (rst_b),
        .inc  (out_valid & ~out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB_A = 32'h0000_0013;
    localparam logic [31:0] BUB_B = 32'h0000_0000;
    localparam logic [31:0] BUB_C = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_b = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
    logic [31:0] a_out_data, b_out_data, c_out_data;
    logic [1:0]  a_occ, b_occ, c_occ;
    logic [15:0] a_stall, c_stall;
    logic [2:0]  b_stall;

    int vectors = 0;
    int miscompares = 0;

    // reference model: FIFO contents per buffering mode plus stall counts
    logic [31:0] exp_q_s[$];
    logic [31:0] exp_q_0[$];
    int unsigned cnt_a = 0, cnt_b = 0, cnt_c = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .BUBBLE(BUB_A), .SKID(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_b(rst_b), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall));

    pipe_stage_reg #(.WIDTH(32), .BUBBLE(BUB_B), .SKID(1), .CNT_W(3)) u_b (
        .clk(clk), .rst_b(rst_b), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall));

    pipe_stage_reg #(.WIDTH(32), .BUBBLE(BUB_C), .SKID(0), .CNT_W(16)) u_c (
        .clk(clk), .rst_b(rst_b), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .occupancy(c_occ), .stall_cnt(c_stall));

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit acc_s, pop_s, acc_0, pop_0;
        acc_s = in_valid && (exp_q_s.size() < 2);
        pop_s = (exp_q_s.size() > 0) && out_ready;
        acc_0 = in_valid && ((exp_q_0.size() == 0) || out_ready);
        pop_0 = (exp_q_0.size() > 0) && out_ready;
        if (rst_b) begin
            exp_q_s.delete();
            exp_q_0.delete();
            cnt_a = 0; cnt_b = 0; cnt_c = 0;
        end else begin
            if ((exp_q_s.size() > 0) && !out_ready) begin
                if (cnt_a < 65535) cnt_a++;
                if (cnt_b < 7) cnt_b++;
            end
            if ((exp_q_0.size() > 0) && !out_ready && (cnt_c < 65535)) cnt_c++;
            if (flush) begin
                exp_q_s.delete();
                exp_q_0.delete();
            end else begin
                if (pop_s) void'(exp_q_s.pop_front());
                if (acc_s) exp_q_s.push_back(in_data);
                if (pop_0) void'(exp_q_0.pop_front());
                if (acc_0) exp_q_0.push_back(in_data);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_b = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hAAAA_AAAA; out_ready = 1'b0;
        tick(); tick();
        #1;
        vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%0b exp=0", a_out_valid); end
        vectors++; if (a_out_data !== BUB_A) begin miscompares++; $display("FAIL reset_data_a got=%h exp=%h", a_out_data, BUB_A); end
        vectors++; if (b_out_data !== BUB_B) begin miscompares++; $display("FAIL reset_data_b got=%h exp=%h", b_out_data, BUB_B); end
        vectors++; if (c_out_data !== BUB_C) begin miscompares++; $display("FAIL reset_data_c got=%h exp=%h", c_out_data, BUB_C); end
        vectors++; if (a_occ !== 2'd0) begin miscompares++; $display("FAIL reset_occ got=%0d exp=0", a_occ); end
        vectors++; if (a_stall !== 16'd0) begin miscompares++; $display("FAIL reset_stall got=%0d exp=0", a_stall); end
        rst_b = 1'b0; in_valid = 1'b0;
        #1;
        vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_a got=%0b exp=1", a_in_ready); end
        vectors++; if (c_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready_c got=%0b exp=1", c_in_ready); end
        tick();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 32'(i);
            #1;
            vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready got=%0b exp=1", a_in_ready); end
            if (i > 1) begin
                vectors++; if (a_out_valid !== 1'b1 || a_out_data !== 32'(i - 1)) begin miscompares++; $display("FAIL stream_out_a got=%0b/%h exp=1/%h", a_out_valid, a_out_data, 32'(i - 1)); end
                vectors++; if (c_out_valid !== 1'b1 || c_out_data !== 32'(i - 1)) begin miscompares++; $display("FAIL stream_out_c got=%0b/%h exp=1/%h", c_out_valid, c_out_data, 32'(i - 1)); end
            end else begin
                vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_first_valid got=%0b exp=0", a_out_valid); end
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        vectors++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h8) begin miscompares++; $display("FAIL stream_last got=%0b/%h exp=1/8", a_out_valid, a_out_data); end
        vectors++; if (c_out_data !== 32'h8) begin miscompares++; $display("FAIL stream_last_c got=%h exp=8", c_out_data); end
        tick();
        #1;
        vectors++; if (a_out_valid !== 1'b0 || a_out_data !== BUB_A) begin miscompares++; $display("FAIL stream_drain got=%0b/%h exp=0/%h", a_out_valid, a_out_data, BUB_A); end
    endtask

    task automatic test_skid_fill();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
        #1;
        vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_ready0 got=%0b exp=1", a_in_ready); end
        tick();
        in_data = 32'h22;
        #1;
        vectors++; if (a_in_ready !== 1'b1 || a_occ !== 2'd1) begin miscompares++; $display("FAIL skid_one got=%0b/%0d exp=1/1", a_in_ready, a_occ); end
        tick();
        in_data = 32'hBAD;
        #1;
        vectors++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_full got=%0d/%0b exp=2/0", a_occ, a_in_ready); end
        vectors++; if (a_out_data !== 32'h11) begin miscompares++; $display("FAIL skid_hold got=%h exp=11", a_out_data); end
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        vectors++; if (a_out_data !== 32'h11 || a_in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_pop1 got=%h/%0b exp=11/0", a_out_data, a_in_ready); end
        tick();
        #1;
        vectors++; if (a_out_data !== 32'h22 || a_in_ready !== 1'b1 || a_occ !== 2'd1) begin miscompares++; $display("FAIL skid_pop2 got=%h/%0b/%0d exp=22/1/1", a_out_data, a_in_ready, a_occ); end
        tick();
        #1;
        vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL skid_empty got=%0b exp=0", a_out_valid); end
    endtask

    task automatic test_flush_priority();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h44;
        #1; tick();
        in_data = 32'h55;
        #1; tick();
        in_data = 32'h33; flush = 1'b1; out_ready = 1'b1;
        #1;
        vectors++; if (a_occ !== 2'd2) begin miscompares++; $display("FAIL flush_pre_occ got=%0d exp=2", a_occ); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        vectors++; if (a_out_valid !== 1'b0 || a_out_data !== BUB_A || a_occ !== 2'd0) begin miscompares++; $display("FAIL flush_a got=%0b/%h/%0d exp=0/%h/0", a_out_valid, a_out_data, a_occ, BUB_A); end
        vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got=%0b exp=1", a_in_ready); end
        vectors++; if (c_out_valid !== 1'b0 || c_out_data !== BUB_C) begin miscompares++; $display("FAIL flush_c got=%0b/%h exp=0/%h", c_out_valid, c_out_data, BUB_C); end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dropped got=%0b/%h exp=0", a_out_valid, a_out_data); end
        end
    endtask

    task automatic test_stall_counter();
        int exp_b;
        rst_b = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1; tick();
        rst_b = 1'b0; in_valid = 1'b1; in_data = 32'h66;
        #1;
        vectors++; if (b_stall !== 3'd0) begin miscompares++; $display("FAIL stall_start got=%0d exp=0", b_stall); end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_b = (i < 7) ? i : 7;
            vectors++; if (b_stall !== 3'(exp_b)) begin miscompares++; $display("FAIL stall_b got=%0d exp=%0d", b_stall, exp_b); end
            vectors++; if (a_stall !== 16'(i)) begin miscompares++; $display("FAIL stall_a got=%0d exp=%0d", a_stall, i); end
            tick();
        end
        #1;
        vectors++; if (b_stall !== 3'd7) begin miscompares++; $display("FAIL stall_sat got=%0d exp=7", b_stall); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        vectors++; if (b_stall !== 3'd7 || b_out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_flush got=%0d/%0b exp=7/0", b_stall, b_out_valid); end
        vectors++; if (a_stall !== 16'd11) begin miscompares++; $display("FAIL stall_flush_a got=%0d exp=11", a_stall); end
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        #1;
        vectors++; if (b_stall !== 3'd0 || a_stall !== 16'd0) begin miscompares++; $display("FAIL stall_reset got=%0d/%0d exp=0/0", b_stall, a_stall); end
        tick();
    endtask

    task automatic test_noskid();
        logic [31:0] exp_d;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h77;
        #1;
        vectors++; if (c_in_ready !== 1'b1) begin miscompares++; $display("FAIL noskid_empty_ready got=%0b exp=1", c_in_ready); end
        tick();
        for (int i = 0; i < 8; i++) begin
            in_data = 32'h78 + 32'(i);
            out_ready = 1'b0;
            #1;
            vectors++; if (c_in_ready !== 1'b0) begin miscompares++; $display("FAIL noskid_ready_lo got=%0b exp=0", c_in_ready); end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            vectors++; if (c_in_ready !== out_ready) begin miscompares++; $display("FAIL noskid_ready_follow got=%0b exp=%0b", c_in_ready, out_ready); end
            exp_d = exp_q_0[0];
            vectors++; if (c_out_valid !== 1'b1 || c_out_data !== exp_d) begin miscompares++; $display("FAIL noskid_order got=%0b/%h exp=1/%h", c_out_valid, c_out_data, exp_d); end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic        e_v_s, e_v_0, e_rdy_s, e_rdy_0;
        logic [31:0] e_da, e_db, e_dc;
        logic [1:0]  e_occ;
        for (int n = 0; n < 400; n++) begin
            rst_b     = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            e_v_s   = (exp_q_s.size() > 0);
            e_v_0   = (exp_q_0.size() > 0);
            e_da    = e_v_s ? exp_q_s[0] : BUB_A;
            e_db    = e_v_s ? exp_q_s[0] : BUB_B;
            e_dc    = e_v_0 ? exp_q_0[0] : BUB_C;
            e_occ   = 2'(exp_q_s.size());
            e_rdy_s = (exp_q_s.size() < 2);
            e_rdy_0 = !e_v_0 || out_ready;
            vectors++; if (a_out_valid !== e_v_s) begin miscompares++; $display("FAIL rnd_valid_a n=%0d got=%0b exp=%0b", n, a_out_valid, e_v_s); end
            vectors++; if (a_out_data !== e_da) begin miscompares++; $display("FAIL rnd_data_a n=%0d got=%h exp=%h", n, a_out_data, e_da); end
            vectors++; if (a_in_ready !== e_rdy_s) begin miscompares++; $display("FAIL rnd_ready_a n=%0d got=%0b exp=%0b", n, a_in_ready, e_rdy_s); end
            vectors++; if (a_occ !== e_occ) begin miscompares++; $display("FAIL rnd_occ_a n=%0d got=%0d exp=%0d", n, a_occ, e_occ); end
            vectors++; if (a_stall !== 16'(cnt_a)) begin miscompares++; $display("FAIL rnd_stall_a n=%0d got=%0d exp=%0d", n, a_stall, cnt_a); end
            vectors++; if (b_out_data !== e_db) begin miscompares++; $display("FAIL rnd_data_b n=%0d got=%h exp=%h", n, b_out_data, e_db); end
            vectors++; if (b_stall !== 3'(cnt_b)) begin miscompares++; $display("FAIL rnd_stall_b n=%0d got=%0d exp=%0d", n, b_stall, cnt_b); end
            vectors++; if (c_out_valid !== e_v_0) begin miscompares++; $display("FAIL rnd_valid_c n=%0d got=%0b exp=%0b", n, c_out_valid, e_v_0); end
            vectors++; if (c_out_data !== e_dc) begin miscompares++; $display("FAIL rnd_data_c n=%0d got=%h exp=%h", n, c_out_data, e_dc); end
            vectors++; if (c_in_ready !== e_rdy_0) begin miscompares++; $display("FAIL rnd_ready_c n=%0d got=%0b exp=%0b", n, c_in_ready, e_rdy_0); end
            vectors++; if (c_occ !== 2'(exp_q_0.size())) begin miscompares++; $display("FAIL rnd_occ_c n=%0d got=%0d exp=%0d", n, c_occ, exp_q_0.size()); end
            vectors++; if (c_stall !== 16'(cnt_c)) begin miscompares++; $display("FAIL rnd_stall_c n=%0d got=%0d exp=%0d", n, c_stall, cnt_c); end
            tick();
        end
        rst_b = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_skid_fill();
        test_flush_priority();
        test_stall_counter();
        test_noskid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
